outlier_tile_scheduler: RTL



---
 rtl/outlier_tile_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/outlier_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : outlier_tile_scheduler
// Purpose  : Buffers one tile of IN_DEPTH row-beats (IN_SIZE FP16 columns
//            each). While filling, it accumulates a sticky per-column outlier
//            mask, which is the OR over all rows of the tile. It then replays
//            the buffered rows in arrival order. Every replayed beat carries
//            the finished tile-wide mask and its popcount, so the downstream
//            int8/FP16 split sees a mask that is valid for every row.
// Ports    : clk_i             - clock; all state changes on the rising edge
//            rst_ni            - asynchronous active-low reset
//            data_in_i         - row beat; element j is column j
//            data_in_valid_i   - upstream valid
//            data_in_ready_o   - upstream ready (high only in FILL, out of reset)
//            data_out_o        - replayed row beat
//            mask_out_o        - tile outlier mask; bit j is column j
//            outlier_count_o   - popcount of mask_out_o
//            data_out_valid_o  - downstream valid (high only in DRAIN)
//            data_out_ready_i  - downstream ready
// Revision : 1.0 - initial release
// ============================================================================
module outlier_tile_scheduler #(
  parameter int          IN_WIDTH   = 16,
  parameter int          IN_SIZE    = 4,
  parameter int          IN_DEPTH   = 4,
  parameter logic [15:0] THRES_BITS = 16'h4F80
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]    data_in_i,
  input  logic                                data_in_valid_i,
  output logic                                data_in_ready_o,
  output logic [IN_SIZE-1:0][IN_WIDTH-1:0]    data_out_o,
  output logic [IN_SIZE-1:0]                  mask_out_o,
  output logic [$clog2(IN_SIZE+1)-1:0]        outlier_count_o,
  output logic                                data_out_valid_o,
  input  logic                                data_out_ready_i
);

  localparam int CNT_W = $clog2(IN_DEPTH);
  localparam int POP_W = $clog2(IN_SIZE+1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IN_DEPTH - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                              state_q, state_d;
  logic [CNT_W-1:0]                    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]                    rd_cnt_q, rd_cnt_d;
  logic [IN_SIZE-1:0]                  mask_q, mask_d;
  logic [POP_W-1:0]                    count_q, count_d;
  logic [IN_SIZE-1:0][IN_WIDTH-1:0]    tile_buf_q [IN_DEPTH];

  logic [IN_SIZE-1:0]                  hit;
  logic [IN_SIZE-1:0]                  mask_upd;
  logic [POP_W-1:0]                    mask_upd_pop;
  logic                                wr_en;
  logic                                in_ready;
  logic                                out_valid;

  // Magnitude compare on the low 15 bits: the sign is dropped, and because
  // FP16 ordering is monotonic in the unsigned encoding, Inf/NaN (exponent
  // all ones) compare above any finite threshold. Equality is not an outlier.
  always_comb begin
    for (int j = 0; j < IN_SIZE; j++) begin
      hit[j] = (data_in_i[j][14:0] > THRES_BITS[14:0]);
    end
  end

  // The popcount is taken from the mask that includes the current (last)
  // beat, so the count lands in the same edge that enters DRAIN.
  assign mask_upd = mask_q | hit;

  always_comb begin
    mask_upd_pop = '0;
    for (int j = 0; j < IN_SIZE; j++) begin
      mask_upd_pop = mask_upd_pop + POP_W'(mask_upd[j]);
    end
  end

  // Next-state and handshake logic
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    mask_d    = mask_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      FILL: begin
        // Gating with rst_ni keeps ready low for the whole reset pulse.
        in_ready = rst_ni;
        if (data_in_valid_i && in_ready) begin
          wr_en  = 1'b1;
          mask_d = mask_upd;
          if (wr_cnt_q == LAST_ROW) begin
            wr_cnt_d = '0;
            count_d  = mask_upd_pop;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        if (data_out_ready_i) begin
          if (rd_cnt_q == LAST_ROW) begin
            rd_cnt_d = '0;
            mask_d   = '0;
            count_d  = '0;
            state_d  = FILL;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      mask_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
    end
  end

  // The tile buffer has no reset. Its contents are only observed in DRAIN,
  // after a full tile has been written.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tile_buf_q[wr_cnt_q] <= data_in_i;
    end
  end

  assign data_in_ready_o  = in_ready;
  assign data_out_valid_o = out_valid;
  assign data_out_o       = tile_buf_q[rd_cnt_q];
  // mask_q accumulates during FILL, so it is hidden until the tile is complete.
  assign mask_out_o       = (state_q == DRAIN) ? mask_q  : '0;
  assign outlier_count_o  = (state_q == DRAIN) ? count_q : '0;

endmodule
`default_nettype wire
